// File: rtl/acumulador_mc.sv
// Multi-channel signed accumulator with per-frame dump-and-clear, optional saturation
// and a sticky per-channel overflow flag.
module acumulador_mc #(
  parameter int N        = 25,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int SAT      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*N-1:0]    In,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_last,
  input  logic              Bandera,
  output logic [2*N-1:0]    Acumulado,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_ovf
);

  localparam int W = 2 * N;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]        acc [CHANNELS];
  logic [CHANNELS-1:0] ovf;

  logic [W-1:0] sel_acc;
  logic         sel_ovf;
  logic         ch_ok;
  logic [W-1:0] sum;
  logic         ovf_now;
  logic [W-1:0] result;
  logic         accept;

  // Channel read goes through a compare mux so an out-of-range index never
  // addresses past the end of the accumulator array.
  always_comb begin
    sel_acc = '0;
    sel_ovf = 1'b0;
    ch_ok   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_W'(i)) begin
        sel_acc = acc[i];
        sel_ovf = ovf[i];
        ch_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    sum     = sel_acc + In;
    ovf_now = (sel_acc[W-1] == In[W-1]) && (sum[W-1] != In[W-1]);
    result  = sum;
    if ((SAT != 0) && ovf_now) begin
      result = In[W-1] ? MAX_NEG : MAX_POS;
    end
    accept  = in_valid && !Bandera && ch_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      ovf       <= '0;
      Acumulado <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (Bandera) begin
        for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
        ovf <= '0;
      end else if (accept) begin
        if (in_last) begin
          Acumulado <= result;
          out_ch    <= in_ch;
          out_ovf   <= sel_ovf | ovf_now;
          out_valid <= 1'b1;
        end
        for (int i = 0; i < CHANNELS; i++) begin
          if (in_ch == CH_W'(i)) begin
            acc[i] <= in_last ? '0 : result;
            ovf[i] <= in_last ? 1'b0 : (ovf[i] | ovf_now);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_acumulador_mc.sv
// Directed bench for acumulador_mc: three instances (saturating, wrapping, 3-channel)
// share one stimulus stream and are checked against hand-computed values.
module tb_acumulador_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [1:0] in_ch;
  logic       in_last;
  logic       bandera;

  logic [7:0] acc_a, acc_w, acc_c;
  logic       val_a, val_w, val_c;
  logic [1:0] ch_a, ch_w, ch_c;
  logic       ovf_a, ovf_w, ovf_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acumulador_mc #(.N(4), .CHANNELS(2), .CH_W(2), .SAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .In(in_data), .in_valid(in_valid), .in_ch(in_ch),
    .in_last(in_last), .Bandera(bandera), .Acumulado(acc_a), .out_valid(val_a),
    .out_ch(ch_a), .out_ovf(ovf_a));

  acumulador_mc #(.N(4), .CHANNELS(2), .CH_W(2), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .In(in_data), .in_valid(in_valid), .in_ch(in_ch),
    .in_last(in_last), .Bandera(bandera), .Acumulado(acc_w), .out_valid(val_w),
    .out_ch(ch_w), .out_ovf(ovf_w));

  acumulador_mc #(.N(4), .CHANNELS(3), .CH_W(2), .SAT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .In(in_data), .in_valid(in_valid), .in_ch(in_ch),
    .in_last(in_last), .Bandera(bandera), .Acumulado(acc_c), .out_valid(val_c),
    .out_ch(ch_c), .out_ovf(ovf_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag,
                      input logic ov, input logic [7:0] oa, input logic [1:0] oc, input logic oo,
                      input logic ev, input logic [7:0] ea, input logic [1:0] ec, input logic eo);
    chk({tag, ".valid"}, 32'(ov), 32'(ev));
    chk({tag, ".acc"},   32'(oa), 32'(ea));
    chk({tag, ".ch"},    32'(oc), 32'(ec));
    chk({tag, ".ovf"},   32'(oo), 32'(eo));
  endtask

  // Drive one cycle of inputs at the falling edge; return 1 ns after the rising edge
  // with the bus idle again.
  task automatic step(input logic v, input logic [1:0] ch, input logic last,
                      input logic band, input logic [7:0] d);
    @(negedge clk);
    in_valid = v; in_ch = ch; in_last = last; bandera = band; in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; bandera = 1'b0; in_ch = 2'd0; in_data = 8'd0;
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'd0; in_valid = 1'b0; in_ch = 2'd0; in_last = 1'b0; bandera = 1'b0;
    #3;
    chk4("reset_a", val_a, acc_a, ch_a, ovf_a, 1'b0, 8'd0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // basic accumulate: 10 + 20 + 5
    step(1, 0, 0, 0, 8'd10);
    chk("acc1_novalid", 32'(val_a), 32'd0);
    step(1, 0, 0, 0, 8'd20);
    step(1, 0, 1, 0, 8'd5);
    chk4("basic_a", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd35, 2'd0, 1'b0);
    chk4("basic_w", val_w, acc_w, ch_w, ovf_w, 1'b1, 8'd35, 2'd0, 1'b0);
    step(0, 0, 0, 0, 8'd0);
    chk4("hold_a", val_a, acc_a, ch_a, ovf_a, 1'b0, 8'd35, 2'd0, 1'b0);

    // interleaved channels
    step(1, 0, 0, 0, 8'd3);
    step(1, 1, 0, 0, 8'(-7));
    step(1, 0, 0, 0, 8'd4);
    step(1, 1, 1, 0, 8'(-1));
    chk4("inter_ch1", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'hF8, 2'd1, 1'b0);
    step(1, 0, 1, 0, 8'd1);
    chk4("inter_ch0", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd8, 2'd0, 1'b0);

    // positive overflow: saturate vs wrap
    step(1, 0, 0, 0, 8'd100);
    step(1, 0, 1, 0, 8'd100);
    chk4("sat_pos", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd127, 2'd0, 1'b1);
    chk4("wrap_pos", val_w, acc_w, ch_w, ovf_w, 1'b1, 8'hC8, 2'd0, 1'b1);
    // negative overflow
    step(1, 1, 0, 0, 8'(-100));
    step(1, 1, 1, 0, 8'(-100));
    chk4("sat_neg", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'h80, 2'd1, 1'b1);
    chk4("wrap_neg", val_w, acc_w, ch_w, ovf_w, 1'b1, 8'h38, 2'd1, 1'b1);
    // flag cleared by the previous dump
    step(1, 0, 1, 0, 8'd1);
    chk4("ovf_clr_a", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd1, 2'd0, 1'b0);
    chk4("ovf_clr_w", val_w, acc_w, ch_w, ovf_w, 1'b1, 8'd1, 2'd0, 1'b0);
    // overflow mid-frame stays sticky through a non-overflowing last sample
    step(1, 0, 0, 0, 8'd100);
    step(1, 0, 0, 0, 8'd100);
    step(1, 0, 1, 0, 8'(-27));
    chk4("sticky_a", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd100, 2'd0, 1'b1);
    chk4("sticky_w", val_w, acc_w, ch_w, ovf_w, 1'b1, 8'hAD, 2'd0, 1'b1);

    // clear has priority over a simultaneous last sample
    step(1, 0, 0, 0, 8'd50);
    step(1, 1, 0, 0, 8'd7);
    step(1, 0, 1, 1, 8'd5);
    chk4("clr_prio", val_a, acc_a, ch_a, ovf_a, 1'b0, 8'd100, 2'd0, 1'b1);
    step(1, 0, 1, 0, 8'd2);
    chk4("after_clr0", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd2, 2'd0, 1'b0);
    step(1, 1, 1, 0, 8'd3);
    chk4("after_clr1", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd3, 2'd1, 1'b0);

    // illegal channel and in_valid low
    step(1, 0, 0, 0, 8'd6);
    step(1, 3, 1, 0, 8'd9);
    chk("illegal_a", 32'(val_a), 32'd0);
    chk("illegal_c", 32'(val_c), 32'd0);
    step(0, 0, 1, 0, 8'd9);
    chk("novalid_last", 32'(val_a), 32'd0);
    step(1, 2, 1, 0, 8'd4);
    chk("ch2_drop_a", 32'(val_a), 32'd0);
    chk4("ch2_c", val_c, acc_c, ch_c, ovf_c, 1'b1, 8'd4, 2'd2, 1'b0);
    step(1, 0, 1, 0, 8'd1);
    chk4("untouched_a", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd7, 2'd0, 1'b0);
    chk4("untouched_c", val_c, acc_c, ch_c, ovf_c, 1'b1, 8'd7, 2'd0, 1'b0);

    // asynchronous reset between edges, mid-frame
    step(1, 0, 0, 0, 8'd30);
    step(1, 1, 1, 0, 8'd5);
    chk4("pre_rst", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd5, 2'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk4("async_rst", val_a, acc_a, ch_a, ovf_a, 1'b0, 8'd0, 2'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, 1, 0, 8'd1);
    chk4("post_rst", val_a, acc_a, ch_a, ovf_a, 1'b1, 8'd1, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
